// File: rtl/vit_encoder_sequencer_if.sv
// Stage-side bus of the ViT encoder sequencer: start/done handshake plus stage/layer position.
interface vit_encoder_sequencer_if #(
  parameter int NUM_STAGES = 6,
  parameter int NUM_LAYERS = 12,
  parameter int LAYER_W    = $clog2(NUM_LAYERS + 1),
  parameter int STAGE_W    = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
);
  logic [NUM_STAGES-1:0] stage_start;
  logic [NUM_STAGES-1:0] stage_done;
  logic [STAGE_W-1:0]    stage_idx;
  logic [LAYER_W-1:0]    layer_idx;
  logic                  layer_last;
  logic                  buf_sel;

  modport master (
    output stage_start, stage_idx, layer_idx, layer_last, buf_sel,
    input  stage_done
  );

  modport slave (
    input  stage_start, stage_idx, layer_idx, layer_last, buf_sel,
    output stage_done
  );
endinterface

// File: rtl/vit_encoder_sequencer.sv
// Multi-layer stage sequencer for the ViT encoder: masked stage chain, layer loop, ping-pong select, abort.
// Optional watchdog with ERR state enabled by defining VIT_SEQ_TIMEOUT_EN.
module vit_encoder_sequencer #(
  parameter int NUM_STAGES  = 6,
  parameter int NUM_LAYERS  = 12,
  parameter int LAYER_W     = $clog2(NUM_LAYERS + 1),
  parameter int STAGE_W     = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [LAYER_W-1:0]    cfg_layers,
  input  logic [NUM_STAGES-1:0] stage_en,
  vit_encoder_sequencer_if.master stg,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic                  error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
`ifdef VIT_SEQ_TIMEOUT_EN
    S_ERR,
`endif
    S_DONE
  } state_t;

  state_t                state_reg, state_next;
  logic [NUM_STAGES-1:0] en_reg, en_next;
  logic [LAYER_W-1:0]    layers_reg, layers_next;
  logic [STAGE_W-1:0]    stage_idx_reg, stage_idx_next;
  logic [LAYER_W-1:0]    layer_idx_reg, layer_idx_next;
  logic                  buf_sel_reg, buf_sel_next;

`ifdef VIT_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_cnt_reg, wd_cnt_next;
  logic            error_reg, error_next;
`endif

  logic [NUM_STAGES-1:0] stage_onehot;
  logic [NUM_STAGES-1:0] above_mask;
  logic                  done_sel;
  logic                  layer_last_int;
  logic                  launch;

  function automatic logic [STAGE_W-1:0] lowest_set(input logic [NUM_STAGES-1:0] v);
    lowest_set = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = STAGE_W'(i);
    end
  endfunction

  function automatic logic [LAYER_W-1:0] clamp_layers(input logic [LAYER_W-1:0] n);
    if (n == '0) return LAYER_W'(1);
    if (n > LAYER_W'(NUM_LAYERS)) return LAYER_W'(NUM_LAYERS);
    return n;
  endfunction

  // above_mask holds the enabled stages strictly after the active one
  for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
    assign stage_onehot[gi] = (stage_idx_reg == STAGE_W'(gi));
    assign above_mask[gi]   = en_reg[gi] && (STAGE_W'(gi) > stage_idx_reg);
  end

  assign done_sel       = |(stg.stage_done & stage_onehot);
  assign layer_last_int = (layers_reg != '0) && (layer_idx_reg == layers_reg - LAYER_W'(1));

  always_comb begin
    state_next     = state_reg;
    en_next        = en_reg;
    layers_next    = layers_reg;
    stage_idx_next = stage_idx_reg;
    layer_idx_next = layer_idx_reg;
    buf_sel_next   = buf_sel_reg;
    launch         = 1'b0;
`ifdef VIT_SEQ_TIMEOUT_EN
    wd_cnt_next    = wd_cnt_reg;
    error_next     = error_reg;
`endif
    if (abort && (state_reg != S_IDLE)) begin
      state_next = S_IDLE;
`ifdef VIT_SEQ_TIMEOUT_EN
      error_next = 1'b0;
`endif
    end else begin
      case (state_reg)
        S_IDLE:  launch = start;
        S_ISSUE: begin
          state_next = S_WAIT;
`ifdef VIT_SEQ_TIMEOUT_EN
          wd_cnt_next = '0;
`endif
        end
        S_WAIT: begin
          if (done_sel) begin
            if (|above_mask) begin
              stage_idx_next = lowest_set(above_mask);
              state_next     = S_ISSUE;
            end else if (layer_last_int) begin
              state_next = S_DONE;
            end else begin
              layer_idx_next = layer_idx_reg + LAYER_W'(1);
              buf_sel_next   = ~buf_sel_reg;
              stage_idx_next = lowest_set(en_reg);
              state_next     = S_ISSUE;
            end
          end
`ifdef VIT_SEQ_TIMEOUT_EN
          else if (wd_cnt_reg == WD_W'(TIMEOUT_CYC - 1)) begin
            state_next = S_ERR;
            error_next = 1'b1;
          end else begin
            wd_cnt_next = wd_cnt_reg + WD_W'(1);
          end
`endif
        end
        S_DONE:  state_next = S_IDLE;
`ifdef VIT_SEQ_TIMEOUT_EN
        S_ERR: begin
          if (start) begin
            launch     = 1'b1;
            error_next = 1'b0;
          end
        end
`endif
        default: state_next = S_IDLE;
      endcase
    end

    // A launch latches a fresh configuration; an empty mask completes without issuing anything
    if (launch) begin
      en_next        = stage_en;
      layers_next    = clamp_layers(cfg_layers);
      layer_idx_next = '0;
      buf_sel_next   = 1'b0;
      stage_idx_next = lowest_set(stage_en);
      state_next     = (stage_en == '0) ? S_DONE : S_ISSUE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      en_reg        <= '0;
      layers_reg    <= '0;
      stage_idx_reg <= '0;
      layer_idx_reg <= '0;
      buf_sel_reg   <= 1'b0;
`ifdef VIT_SEQ_TIMEOUT_EN
      wd_cnt_reg    <= '0;
      error_reg     <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      en_reg        <= en_next;
      layers_reg    <= layers_next;
      stage_idx_reg <= stage_idx_next;
      layer_idx_reg <= layer_idx_next;
      buf_sel_reg   <= buf_sel_next;
`ifdef VIT_SEQ_TIMEOUT_EN
      wd_cnt_reg    <= wd_cnt_next;
      error_reg     <= error_next;
`endif
    end
  end

  // abort suppresses the issue pulse and the done pulse in its own cycle
  assign stg.stage_start = (state_reg == S_ISSUE && !abort) ? stage_onehot : '0;
  assign stg.stage_idx   = stage_idx_reg;
  assign stg.layer_idx   = layer_idx_reg;
  assign stg.layer_last  = layer_last_int;
  assign stg.buf_sel     = buf_sel_reg;
  assign busy            = (state_reg != S_IDLE);
  assign done            = (state_reg == S_DONE) && !abort;
  assign aborted         = abort && busy;
`ifdef VIT_SEQ_TIMEOUT_EN
  assign error           = error_reg;
`else
  assign error           = 1'b0;
`endif

endmodule

// File: tb/tb_vit_encoder_sequencer.sv
// Directed, table-driven bench for vit_encoder_sequencer with an automatic one-cycle stage responder.
module tb_vit_encoder_sequencer;
  localparam int NS = 6;
  localparam int NL = 12;
  localparam int LW = $clog2(NL + 1);
  localparam int SW = $clog2(NS);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [LW-1:0] cfg_layers = '0;
  logic [NS-1:0] stage_en = '0;
  logic [NS-1:0] hang_mask = '0;
  logic busy, done, aborted, error;

  vit_encoder_sequencer_if #(.NUM_STAGES(NS), .NUM_LAYERS(NL)) sif ();

  vit_encoder_sequencer #(.NUM_STAGES(NS), .NUM_LAYERS(NL), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_layers(cfg_layers), .stage_en(stage_en), .stg(sif),
    .busy(busy), .done(done), .aborted(aborted), .error(error)
  );

  always #5 clk = ~clk;

  // every started stage answers one cycle later unless it is marked as hung
  always @(posedge clk or posedge rst) begin
    if (rst) sif.stage_done <= '0;
    else     sif.stage_done <= sif.stage_start & ~hang_mask;
  end

  int log_stage[$];
  int log_layer[$];
  int log_buf[$];
  int log_last[$];
  int bad_onehot = 0;
  int done_cnt = 0;
  int abort_cnt = 0;

  always @(negedge clk) begin
    #2;
    if (sif.stage_start != '0) begin
      if (!$onehot(sif.stage_start)) bad_onehot++;
      for (int i = 0; i < NS; i++) begin
        if (sif.stage_start[i]) begin
          log_stage.push_back(i);
          log_layer.push_back(int'(sif.layer_idx));
          log_buf.push_back(int'(sif.buf_sel));
          log_last.push_back(int'(sif.layer_last));
        end
      end
    end
    if (done) done_cnt++;
    if (aborted) abort_cnt++;
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    log_stage.delete();
    log_layer.delete();
    log_buf.delete();
    log_last.delete();
    bad_onehot = 0;
    done_cnt = 0;
    abort_cnt = 0;
  endtask

  // start sampled in cycle 0; returns the cycle in which done is seen (-1 on timeout)
  task automatic run_seq(input logic [NS-1:0] mask, input logic [LW-1:0] layers,
                         input bit hold_start, output int done_cyc);
    int cyc;
    @(negedge clk);
    stage_en = mask;
    cfg_layers = layers;
    start = 1'b1;
    @(negedge clk);
    if (!hold_start) start = 1'b0;
    stage_en = ~mask;
    cfg_layers = layers + LW'(3);
    cyc = 1;
    done_cyc = -1;
    while (cyc < 400) begin
      if (done) begin
        done_cyc = cyc;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
  endtask

  typedef struct {
    logic [NS-1:0] mask;
    logic [LW-1:0] layers;
    int exp_l;
    int exp_pulses;
    int exp_cyc;
    int exp_layer_idx;
    int exp_buf;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int dc;
    int bad;
    int k;
    bit found;

    vecs[0] = '{6'b111111, 4'd2,  2,  12, 25,  1, 1};
    vecs[1] = '{6'b100101, 4'd1,  1,   3,  7,  0, 0};
    vecs[2] = '{6'b000000, 4'd3,  1,   0,  1,  0, 0};
    vecs[3] = '{6'b111111, 4'd0,  1,   6, 13,  0, 0};
    vecs[4] = '{6'b000001, 4'd15, 12, 12, 25, 11, 1};
    vecs[5] = '{6'b010010, 4'd3,  3,   6, 13,  2, 0};
    vecs[6] = '{6'b100000, 4'd12, 12, 12, 25, 11, 1};

    #3;
    chk("reset_outputs", {sif.stage_start, sif.stage_idx, sif.layer_idx, sif.layer_last,
                          sif.buf_sel, busy, done, aborted, error}, '0);
    #20;
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("post_reset_busy", busy, 0);

    for (int v = 0; v < 7; v++) begin
      clear_logs();
      run_seq(vecs[v].mask, vecs[v].layers, 1'b0, dc);
      @(negedge clk);
      #3;
      chk("done_cycle", dc, vecs[v].exp_cyc);
      chk("pulse_count", log_stage.size(), vecs[v].exp_pulses);
      bad = bad_onehot;
      k = 0;
      for (int l = 0; l < vecs[v].exp_l; l++) begin
        for (int s = 0; s < NS; s++) begin
          if (vecs[v].mask[s]) begin
            if (k >= log_stage.size()) bad++;
            else if (log_stage[k] != s || log_layer[k] != l || log_buf[k] != (l % 2) ||
                     log_last[k] != int'(l == vecs[v].exp_l - 1)) bad++;
            k++;
          end
        end
      end
      chk("pulse_order", bad, 0);
      chk("final_layer_idx", sif.layer_idx, vecs[v].exp_layer_idx);
      chk("final_buf_sel", sif.buf_sel, vecs[v].exp_buf);
      chk("done_pulses", done_cnt, 1);
      chk("idle_after_done", busy, 0);
      $display("vec %0d mask=%b layers=%0d done_cycle=%0d pulses=%0d",
               v, vecs[v].mask, vecs[v].layers, dc, log_stage.size());
    end

    // abort during WAIT of stage 3 in layer 1; that stage's done in the same cycle is ignored
    clear_logs();
    @(negedge clk);
    stage_en = 6'b111111;
    cfg_layers = 4'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (sif.stage_start[3] && sif.layer_idx == 1) found = 1'b1;
      else @(negedge clk);
    end
    chk("abort_reach_stage3_layer1", found, 1);
    @(negedge clk);
    abort = 1'b1;
    #1;
    chk("abort_pulse", aborted, 1);
    chk("abort_stage_idx", sif.stage_idx, 3);
    @(negedge clk);
    abort = 1'b0;
    #1;
    chk("abort_idle", busy, 0);
    chk("abort_pulse_end", aborted, 0);
    repeat (3) @(negedge clk);
    #3;
    chk("abort_count", abort_cnt, 1);
    chk("abort_no_done", done_cnt, 0);
    $display("abort in WAIT: aborted_pulses=%0d done_pulses=%0d", abort_cnt, done_cnt);

    clear_logs();
    run_seq(6'b111111, 4'd1, 1'b0, dc);
    @(negedge clk);
    #3;
    chk("rerun_done_cycle", dc, 13);
    chk("rerun_first_layer", (log_layer.size() > 0) ? log_layer[0] : -1, 0);
    $display("rerun after abort: done_cycle=%0d", dc);

    // abort in ISSUE must suppress the start pulse in that cycle
    clear_logs();
    @(negedge clk);
    stage_en = 6'b000100;
    cfg_layers = 4'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b1;
    #1;
    chk("abort_issue_no_start", sif.stage_start, 0);
    chk("abort_issue_pulse", aborted, 1);
    @(negedge clk);
    abort = 1'b0;
    #3;
    chk("abort_issue_idle", busy, 0);
    chk("abort_issue_pulses", log_stage.size(), 0);
    $display("abort in ISSUE: stage_pulses=%0d", log_stage.size());

    // abort in IDLE has no effect
    @(negedge clk);
    abort = 1'b1;
    #1;
    chk("abort_idle_no_pulse", aborted, 0);
    @(negedge clk);
    abort = 1'b0;
    #1;
    chk("abort_idle_stays_idle", busy, 0);
    $display("abort in IDLE: busy=%0d", busy);

    // start held through the whole run, including the DONE cycle, must not relaunch
    clear_logs();
    run_seq(6'b000011, 4'd1, 1'b1, dc);
    chk("held_start_done_cycle", dc, 5);
    @(negedge clk);
    #3;
    chk("held_start_no_restart", busy, 0);
    chk("held_start_pulses", log_stage.size(), 2);
    $display("start held while busy: done_cycle=%0d pulses=%0d", dc, log_stage.size());

    // asynchronous reset taking effect between clock edges
    @(negedge clk);
    stage_en = 6'b111111;
    cfg_layers = 4'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_outputs", {sif.stage_start, sif.stage_idx, sif.layer_idx,
                                busy, done, aborted, error}, '0);
    #1;
    rst = 1'b0;
    $display("async reset mid-run: busy=%0d", busy);

`ifdef VIT_SEQ_TIMEOUT_EN
    // stage 4 never answers: ERR is entered after 16 WAIT cycles
    clear_logs();
    hang_mask = 6'b010000;
    @(negedge clk);
    stage_en = 6'b111111;
    cfg_layers = 4'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dc = -1;
    for (int c = 1; c < 200; c++) begin
      if (error) begin
        dc = c;
        break;
      end
      @(negedge clk);
    end
    chk("timeout_cycle", dc, 26);
    chk("timeout_stage_idx", sif.stage_idx, 4);
    chk("timeout_layer_idx", sif.layer_idx, 0);
    chk("timeout_busy", busy, 1);
    repeat (3) @(negedge clk);
    #3;
    chk("timeout_sticky", error, 1);
    chk("timeout_no_done", done_cnt, 0);
    $display("watchdog: error_cycle=%0d stage_idx=%0d", dc, sif.stage_idx);
    hang_mask = '0;
    clear_logs();
    run_seq(6'b000001, 4'd1, 1'b0, dc);
    chk("timeout_restart_done_cycle", dc, 3);
    chk("timeout_error_cleared", error, 0);
    $display("restart from ERR: done_cycle=%0d error=%0d", dc, error);
`endif

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "bench time limit reached");
  end

endmodule

// File: doc/vit_encoder_sequencer.md
Name: vit_encoder_sequencer

Overview:
Parametrised, multi-layer control sequencer for the ViT encoder datapath. It drives up to NUM_STAGES compute units (LN1, ATT, RES1, LN2, MLP, RES2 by default) with a start/done handshake. The whole stage chain repeats for a run-time number of layers, and a ping-pong buffer select toggles at each layer boundary. Over the single-layer block controller it adds a stage-enable mask (skip stages), a layer loop, abort, and an optional watchdog.

Parameters:
NUM_STAGES, 6, number of sequenced compute stages; index 0 issues first.
NUM_LAYERS, 12, maximum encoder layers per run.
LAYER_W, $clog2(NUM_LAYERS+1), width of layer count and index (derived).
STAGE_W, $clog2(NUM_STAGES), width of stage index (derived; minimum 1).
TIMEOUT_CYC, 65535, watchdog limit in cycles (used only with the optional feature).

Ports:
clk  in  1  clock.
rst  in  1  asynchronous, active-high reset.
start  in  1  begin run; sampled only in IDLE.
abort  in  1  cancel run; returns the block to IDLE.
cfg_layers  in  LAYER_W  number of layers, latched at start.
stage_en  in  NUM_STAGES  stage-enable mask, latched at start; 0 = skip that stage.
stage_start  out  NUM_STAGES  one-hot, one-cycle start pulse to the active stage.
stage_done  in  NUM_STAGES  per-stage done pulse.
stage_idx  out  STAGE_W  active stage index.
layer_idx  out  LAYER_W  active layer, 0-based.
layer_last  out  1  high while layer_idx equals latched layers-1.
buf_sel  out  1  ping-pong buffer select for the current layer.
busy  out  1  high in any state other than IDLE.
done  out  1  one-cycle pulse on successful completion.
aborted  out  1  one-cycle pulse when an abort is taken.
error  out  1  sticky watchdog error (only with the optional feature).

Behaviour:
- Reset: async, active-high; state is forced to IDLE. All outputs go to 0: stage_start, stage_idx, layer_idx, layer_last, buf_sel, busy, done, aborted, error. Latched configuration registers also clear to 0.
- States: IDLE, ISSUE, WAIT, DONE, ERR. ERR exists only with the optional feature.
- IDLE, on start=1:
  - latch stage_en and cfg_layers;
  - clamp the layer count: 0 becomes 1, values above NUM_LAYERS become NUM_LAYERS;
  - layer_idx=0, buf_sel=0;
  - stage_idx = lowest set bit of the mask, then go to ISSUE;
  - if the mask is all zero, go directly to DONE and issue no stages.
- ISSUE: assert stage_start[stage_idx] for exactly one cycle, then go to WAIT.
- WAIT: sample only stage_done[stage_idx]; done bits of other stages are ignored. On done:
  - if a higher-index enabled stage exists, stage_idx takes the next such stage and the FSM goes to ISSUE;
  - otherwise, if layer_last=1, go to DONE;
  - otherwise layer_idx+1, buf_sel toggles, stage_idx = lowest enabled stage, and the FSM goes to ISSUE.
- stage_done is not sampled in ISSUE. Stages must respond no earlier than the cycle after their start pulse.
- DONE: done=1 for one cycle, then IDLE. layer_idx and buf_sel hold their final values until the next start.
- start while busy=1 is ignored. start and a run-ending event in the same cycle does not begin a new run; start must be reissued from IDLE.
- abort in any non-IDLE state: next state is IDLE, aborted=1 for one cycle, done is not pulsed, and stage_start is forced to 0 in that same cycle. abort has priority over start, stage_done and the watchdog. abort in IDLE has no effect.
- Latency, when every stage returns done one cycle after its start:
  - start sampled in cycle 0, first stage_start in cycle 1;
  - done in cycle 2*L*S+1, where L is the clamped layer count and S is the number of enabled stages;
  - with an all-zero mask, done is in cycle 1.
- Mid-run changes to stage_en or cfg_layers have no effect on the current run.

Optional Feature:
VIT_SEQ_TIMEOUT_EN
- Defined:
  - a cycle counter clears on each entry to WAIT and increments every cycle spent in WAIT;
  - reaching TIMEOUT_CYC without the awaited done moves the FSM to ERR and sets error=1 (sticky);
  - stage_idx and layer_idx freeze at the failing stage and layer;
  - ERR holds until start (clears error, begins a new run) or abort (clears error, goes to IDLE, pulses aborted);
  - done is never pulsed for a timed-out run.
- Undefined: no counter and no ERR state; WAIT waits indefinitely and error is tied to 0.

Test Plan:
- Stage mask 6'b111111, cfg_layers=2, each stage_done one cycle after its start -> 12 stage_start pulses in order 0..5,0..5; buf_sel 0 for the first 6 and 1 for the last 6; done in cycle 25.
- Stage mask 6'b100101, cfg_layers=1 -> stage_start only on stages 0, 2, 5; done in cycle 7.
- Stage mask 0 -> done in cycle 1; no stage_start pulses.
- cfg_layers=0, then cfg_layers=15 with NUM_LAYERS=12 -> runs of 1 and 12 layers respectively; layer_last is high only in the final layer.
- abort asserted in WAIT of stage 3, layer 1 -> IDLE next cycle, aborted pulses once, no done; a second start afterwards runs cleanly from layer 0.
- With VIT_SEQ_TIMEOUT_EN and TIMEOUT_CYC=16, stage 4 never returns done -> error=1 after 16 WAIT cycles with stage_idx=4; a new start clears error.
